// File: rtl/fifo_pipe_proc.sv
// fifo_pipe_proc: single-clock FIFO feeding an NUM_STAGES-deep arithmetic
// pipeline. Each popped word carries its own op (pass/add/sub/sat-add),
// which every stage applies once, so the op takes effect NUM_STAGES times.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   push        write request, push_data written when accepted
//   pop         read request, op_mode selects the op for that word
//   flush       synchronous clear of FIFO and pipeline (error flags kept)
//   err_clr     clears sticky overflow/underflow (a same-cycle error wins)
//   pop_data    processed word, 0 when pop_valid=0
//   pop_valid   pop_data valid this cycle (NUM_STAGES cycles after the pop)
//   empty, full, almost_full, level   occupancy status from registered state
//   overflow    sticky: a push was dropped
//   underflow   sticky: a pop was ignored
module fifo_pipe_proc #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_WIDTH = 11,
  parameter int NUM_STAGES = 3,
  parameter int STEP       = 1,
  parameter int AF_THRESH  = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [FIFO_WIDTH-1:0]         push_data,
  input  logic                          pop,
  input  logic [1:0]                    op_mode,
  input  logic                          flush,
  input  logic                          err_clr,
  output logic [FIFO_WIDTH-1:0]         pop_data,
  output logic                          pop_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH-1:0] STEP_W = FIFO_WIDTH'(STEP);
  localparam logic [AW:0]           AF_LVL = (AW+1)'(AF_THRESH);

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_SAT  = 2'b11
  } op_e;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;

  logic [FIFO_WIDTH-1:0] stg_data [NUM_STAGES];
  op_e                   stg_op   [NUM_STAGES];
  logic                  stg_vld  [NUM_STAGES];

  function automatic logic [FIFO_WIDTH-1:0] apply_op(
    input logic [FIFO_WIDTH-1:0] d,
    input op_e                   op
  );
    logic [FIFO_WIDTH:0] sum;
    sum = {1'b0, d} + {1'b0, STEP_W};
    case (op)
      OP_PASS: apply_op = d;
      OP_ADD:  apply_op = sum[FIFO_WIDTH-1:0];
      OP_SUB:  apply_op = d - STEP_W;
      default: apply_op = sum[FIFO_WIDTH] ? '1 : sum[FIFO_WIDTH-1:0];
    endcase
  endfunction

  // Status is derived purely from the pointer registers.
  assign level       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full = (level >= AF_LVL);

  // A pop frees the slot in the same cycle, so push on full is allowed then.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; a read of the slot being overwritten sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_acc) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      if (push && !push_acc) overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (pop && empty)      underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        stg_data[k] <= '0;
        stg_op[k]   <= OP_PASS;
        stg_vld[k]  <= 1'b0;
      end
    end else begin
      stg_vld[0]  <= pop_acc;
      stg_op[0]   <= op_e'(op_mode);
      stg_data[0] <= pop_acc ? apply_op(mem[rd_ptr[AW-1:0]], op_e'(op_mode)) : '0;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        stg_vld[k]  <= stg_vld[k-1];
        stg_op[k]   <= stg_op[k-1];
        stg_data[k] <= stg_vld[k-1] ? apply_op(stg_data[k-1], stg_op[k-1]) : '0;
      end
    end
  end

  assign pop_data  = stg_data[NUM_STAGES-1];
  assign pop_valid = stg_vld[NUM_STAGES-1];

endmodule

// File: tb/tb_fifo_pipe_proc.sv
// Testbench for fifo_pipe_proc: directed vector table plus hand-written
// sequences for full/overflow, pointer wrap, flush and mid-stream reset.
module tb_fifo_pipe_proc;

  localparam int DEPTH = 8;
  localparam int WIDTH = 11;
  localparam int NSTG  = 3;
  localparam int STEPV = 1;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst, push, pop, flush, err_clr;
  logic [WIDTH-1:0] push_data;
  logic [1:0]       op_mode;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid, empty, full, almost_full, overflow, underflow;
  logic [3:0]       level;

  int checks = 0;
  int errors = 0;
  int mq[$];     // model FIFO contents
  int exp_q[$];  // expected pipeline outputs

  always #5 clk = ~clk;

  fifo_pipe_proc #(
    .FIFO_DEPTH(DEPTH),
    .FIFO_WIDTH(WIDTH),
    .NUM_STAGES(NSTG),
    .STEP(STEPV),
    .AF_THRESH(DEPTH - 2)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .op_mode(op_mode), .flush(flush), .err_clr(err_clr), .pop_data(pop_data),
    .pop_valid(pop_valid), .empty(empty), .full(full), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic push; int pd; logic pop; int op; logic clr;
    logic ev; int ed; int el; logic ee; logic ef; logic eaf; logic eovf; logic eunf;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic pu, int pd, logic po, int op, logic clr,
                              logic ev, int ed, int el, logic ee, logic ef,
                              logic eaf, logic eovf, logic eunf);
    vec_t v;
    v.push = pu; v.pd = pd; v.pop = po; v.op = op; v.clr = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.ee = ee; v.ef = ef;
    v.eaf = eaf; v.eovf = eovf; v.eunf = eunf;
    return v;
  endfunction

  // Expected result of NSTG applications of op to d.
  function automatic int model(int d, int op);
    int r = d;
    for (int s = 0; s < NSTG; s++) begin
      case (op)
        1: r = (r + STEPV) % (MAXV + 1);
        2: r = (r + MAXV + 1 - STEPV) % (MAXV + 1);
        3: r = (r + STEPV > MAXV) ? MAXV : r + STEPV;
        default: r = r;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick and score any output word against the expected queue.
  task automatic tick_sb();
    tick();
    if (pop_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else                   chk("sb_data", int'(pop_data), exp_q.pop_front());
    end else begin
      chk("idle_data_zero", int'(pop_data), 0);
    end
  endtask

  // Drive one cycle and update the model FIFO/scoreboard accordingly.
  task automatic drive(input logic pu, input int pd, input logic po, input int op);
    push = pu; push_data = WIDTH'(pd); pop = po; op_mode = 2'(op);
    if (po && mq.size() > 0) exp_q.push_back(model(mq.pop_front(), op));
    if (pu) mq.push_back(pd);
    tick_sb();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; push = 0; push_data = '0; pop = 0; op_mode = '0; flush = 0; err_clr = 0;

    vecs[0]  = mk(1, 5,     0, 0, 0,  0, 0,     1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,     1, 1, 0,  0, 0,     0, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0,     0, 0, 0,  0, 0,     0, 1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0,     0, 0, 0,  1, 8,     0, 1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0,     0, 0, 0,  0, 0,     0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0,     1, 0, 0,  0, 0,     0, 1, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0,     0, 0, 0,  0, 0,     0, 1, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0,     0, 0, 1,  0, 0,     0, 1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0,     1, 0, 1,  0, 0,     0, 1, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0,     0, 0, 1,  0, 0,     0, 1, 0, 0, 0, 0);
    vecs[10] = mk(1, 'h000, 0, 0, 0,  0, 0,     1, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 'h7FE, 0, 0, 0,  0, 0,     2, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 'h001, 0, 0, 0,  0, 0,     3, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 'h7FE, 0, 0, 0,  0, 0,     4, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0,     1, 0, 0,  0, 0,     3, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0,     1, 1, 0,  0, 0,     2, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0,     1, 2, 0,  1, 'h000, 1, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0,     1, 3, 0,  1, 'h001, 0, 1, 0, 0, 0, 0);
    vecs[18] = mk(0, 0,     0, 0, 0,  1, 'h7FE, 0, 1, 0, 0, 0, 0);
    vecs[19] = mk(0, 0,     0, 0, 0,  1, 'h7FF, 0, 1, 0, 0, 0, 0);
    vecs[20] = mk(0, 0,     0, 0, 0,  0, 0,     0, 1, 0, 0, 0, 0);

    tick(); tick();
    rst = 0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", pop_valid, 0);
    chk("rst_data", pop_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // Table: single word latency, underflow/err_clr, four ops with wrap/saturation.
    for (int i = 0; i < 21; i++) begin
      push = vecs[i].push; push_data = WIDTH'(vecs[i].pd); pop = vecs[i].pop;
      op_mode = 2'(vecs[i].op); err_clr = vecs[i].clr;
      tick();
      chk($sformatf("v%0d_valid", i), pop_valid, vecs[i].ev);
      chk($sformatf("v%0d_data", i), pop_data, vecs[i].ed);
      chk($sformatf("v%0d_level", i), level, vecs[i].el);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].ee);
      chk($sformatf("v%0d_full", i), full, vecs[i].ef);
      chk($sformatf("v%0d_af", i), almost_full, vecs[i].eaf);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].eovf);
      chk($sformatf("v%0d_unf", i), underflow, vecs[i].eunf);
    end
    push = 0; pop = 0; err_clr = 0;

    // Fill to full, overflow, then simultaneous push+pop on full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i, 0, 0);
      chk("fill_level", level, i + 1);
      chk("fill_full", full, (i == DEPTH - 1) ? 1 : 0);
      chk("fill_af", almost_full, (i + 1 >= DEPTH - 2) ? 1 : 0);
    end
    push = 1; push_data = WIDTH'(99); pop = 0;
    tick_sb();
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, DEPTH);
    chk("ovf_full", full, 1);
    push = 0; err_clr = 1;
    tick_sb();
    chk("ovf_clr", overflow, 0);
    err_clr = 0;
    drive(1, 100, 1, 0);
    chk("fullpp_level", level, DEPTH);
    chk("fullpp_full", full, 1);
    chk("fullpp_ovf", overflow, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 0);
    for (int i = 0; i < NSTG + 1; i++) drive(0, 0, 0, 0);
    chk("full_drain_empty", empty, 1);
    chk("full_drain_sb", exp_q.size(), 0);

    // Streaming at level 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) drive(1, 300 + i, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 310 + i, 1, i % 4);
      chk("wrap_level", level, 3);
      chk("wrap_empty", empty, 0);
      chk("wrap_full", full, 0);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    for (int i = 0; i < NSTG + 1; i++) drive(0, 0, 0, 0);
    chk("wrap_drain_sb", exp_q.size(), 0);
    chk("wrap_drain_empty", empty, 1);

    // Flush with 2 words in the pipeline and 3 in the FIFO; sticky flag kept.
    drive(0, 0, 1, 0);
    chk("pre_flush_unf", underflow, 1);
    for (int i = 0; i < 5; i++) begin
      push = 1; push_data = WIDTH'(400 + i); pop = 0;
      tick_sb();
    end
    push = 0; pop = 1; op_mode = 2'd1;
    tick_sb(); tick_sb();
    pop = 0; flush = 1;
    tick();
    flush = 0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_valid", pop_valid, 0);
    chk("flush_unf_kept", underflow, 1);
    chk("flush_ovf_kept", overflow, 0);
    for (int i = 0; i < NSTG + 3; i++) tick_sb();
    chk("flush_sb", exp_q.size(), 0);

    // Mid-stream reset clears everything including sticky flags.
    push = 1; push_data = WIDTH'(500); tick_sb();
    push_data = WIDTH'(501); tick_sb();
    push = 0; pop = 1; tick_sb();
    pop = 0; rst = 1;
    tick();
    rst = 0;
    chk("mrst_level", level, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_unf", underflow, 0);
    chk("mrst_valid", pop_valid, 0);
    for (int i = 0; i < NSTG + 2; i++) tick_sb();

    // Still operational after reset.
    drive(1, 'h7FD, 0, 0);
    drive(0, 0, 1, 3);
    for (int i = 0; i < NSTG + 1; i++) drive(0, 0, 0, 0);
    chk("post_rst_sb", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
